// File: rtl/cu_pkg.sv
// ----------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the multi-cycle MIPS-subset control unit:
//   - cu_state_e : FSM state encoding (also exported on the debug port)
//   - OP_* / FN_* : opcode and R-type funct encodings of the legal subset
//   - ALU_*       : cu_alu_op encodings
//   - PC_SEL_*    : cu_pc_sel encodings
//   - cu_dec_t    : instruction class bundle produced by cu_decode
// ----------------------------------------------------------------------------
package cu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } cu_state_e;

    // Opcodes (inst[INST_W-1 -: 6])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (inst[5:0])
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    // Next-PC source encodings
    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

    // Instruction class. itype covers every I-format instruction (ALU-imm,
    // lui, loads, stores, branches); branch_ne separates bne from beq.
    typedef struct packed {
        logic       rtype;
        logic       itype;
        logic       load;
        logic       store;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       link;
        logic       zero_ext;
        logic       write_imm;
        logic       illegal;
        logic [2:0] alu_op;
    } cu_dec_t;

endpackage

// File: rtl/cu_decode.sv
// ----------------------------------------------------------------------------
// cu_decode
// Purely combinational instruction classifier for the multi-cycle control
// unit. Maps opcode/funct onto an instruction class bundle and the ALU
// operation used during EXEC/MEM/WB. Anything outside the legal subset
// (unknown opcode, or R-type with an unknown funct) raises o_dec.illegal
// with every other field cleared.
//
// Ports:
//   i_opcode  in  6         instruction opcode field
//   i_funct   in  6         R-type funct field
//   o_dec     out cu_dec_t  instruction class + alu_op
// ----------------------------------------------------------------------------
module cu_decode
    import cu_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output cu_dec_t    o_dec
);

    always_comb begin
        o_dec = '0;
        case (i_opcode)
            OP_RTYPE: begin
                o_dec.rtype = 1'b1;
                case (i_funct)
                    FN_ADDU: o_dec.alu_op = ALU_ADD;
                    FN_SUBU: o_dec.alu_op = ALU_SUB;
                    FN_AND:  o_dec.alu_op = ALU_AND;
                    FN_OR:   o_dec.alu_op = ALU_OR;
                    FN_SLT:  o_dec.alu_op = ALU_SLT;
                    default: begin
                        o_dec.rtype   = 1'b0;
                        o_dec.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDIU: begin
                o_dec.itype  = 1'b1;
                o_dec.alu_op = ALU_ADD;
            end
            OP_ANDI: begin
                o_dec.itype    = 1'b1;
                o_dec.zero_ext = 1'b1;
                o_dec.alu_op   = ALU_AND;
            end
            OP_ORI: begin
                o_dec.itype    = 1'b1;
                o_dec.zero_ext = 1'b1;
                o_dec.alu_op   = ALU_OR;
            end
            OP_LUI: begin
                o_dec.itype     = 1'b1;
                o_dec.write_imm = 1'b1;
                o_dec.alu_op    = ALU_ADD;
            end
            OP_LW: begin
                o_dec.itype  = 1'b1;
                o_dec.load   = 1'b1;
                o_dec.alu_op = ALU_ADD;
            end
            OP_SW: begin
                o_dec.itype  = 1'b1;
                o_dec.store  = 1'b1;
                o_dec.alu_op = ALU_ADD;
            end
            OP_BEQ: begin
                o_dec.itype  = 1'b1;
                o_dec.branch = 1'b1;
                o_dec.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                o_dec.itype     = 1'b1;
                o_dec.branch    = 1'b1;
                o_dec.branch_ne = 1'b1;
                o_dec.alu_op    = ALU_SUB;
            end
            OP_J: begin
                o_dec.jump = 1'b1;
            end
            OP_JAL: begin
                o_dec.jump = 1'b1;
                o_dec.link = 1'b1;
            end
            default: begin
                o_dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cu_multicycle.sv
// ----------------------------------------------------------------------------
// cu_multicycle
// Multi-cycle control unit for the MIPS-subset core. A seven-state FSM
// (IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP) sequences a shared-memory datapath.
// All control outputs are combinational from the state register and the
// decoded IR, so an asynchronous reset clears every strobe immediately.
//
// Memory handshake: a request (cu_mem_re or cu_mem_we, address chosen by
// cu_iord) is held stable for as long as the FSM stays in FETCH or MEM; the
// access completes in the cycle mem_ready is sampled high, and the FSM leaves
// that state on the same rising edge. mem_ready is ignored in other states.
//
// Optional feature macro: CU_PERF_CNT_EN adds cu_cycle_cnt / cu_retire_cnt.
//
// Ports:
//   clk            in   1         rising-edge clock
//   rst_n          in   1         asynchronous active-low reset
//   inst           in   INST_W    IR contents, valid from DECODE onward
//   alu_zero       in   1         ALU result == 0, used in EXEC for branches
//   mem_ready      in   1         memory completes current access this cycle
//   cu_mem_re      out  1         memory read request
//   cu_mem_we      out  1         memory write request (MEM state only)
//   cu_iord        out  1         address source: 0 PC, 1 ALU result
//   cu_ir_we       out  1         load IR
//   cu_pc_we       out  1         update PC
//   cu_pc_sel      out  2         0 PC+4, 1 branch target, 2 jump target
//   cu_reg_we      out  1         register file write
//   cu_write2rt    out  1         destination rt (else rd)
//   cu_link        out  1         destination LINK_REG, data PC (jal)
//   cu_imm2alu     out  1         ALU B operand is the immediate
//   cu_zero_ext    out  1         zero-extend immediate
//   cu_write_imm   out  1         writeback imm<<16 (lui)
//   cu_read_data   out  1         writeback from memory (lw)
//   cu_alu_op      out  ALU_OP_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
//   cu_illegal     out  1         sticky illegal-instruction flag (TRAP)
//   cu_cycle_cnt   out  32        [CU_PERF_CNT_EN] active cycle counter
//   cu_retire_cnt  out  32        [CU_PERF_CNT_EN] retired instruction count
//   cu_dbg_state   out  3         current FSM state (cu_state_e encoding)
// ----------------------------------------------------------------------------
module cu_multicycle
    import cu_pkg::*;
#(
    parameter int INST_W   = 32,
    parameter int ALU_OP_W = 3,
    parameter int LINK_REG = 31
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INST_W-1:0]   inst,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                cu_mem_re,
    output logic                cu_mem_we,
    output logic                cu_iord,
    output logic                cu_ir_we,
    output logic                cu_pc_we,
    output logic [1:0]          cu_pc_sel,
    output logic                cu_reg_we,
    output logic                cu_write2rt,
    output logic                cu_link,
    output logic                cu_imm2alu,
    output logic                cu_zero_ext,
    output logic                cu_write_imm,
    output logic                cu_read_data,
    output logic [ALU_OP_W-1:0] cu_alu_op,
    output logic                cu_illegal,
`ifdef CU_PERF_CNT_EN
    output logic [31:0]         cu_cycle_cnt,
    output logic [31:0]         cu_retire_cnt,
`endif
    output logic [2:0]          cu_dbg_state
);

    // A link to r0 would be discarded by the register file, so the link
    // write is only issued when LINK_REG names a real register.
    localparam bit LINK_OK = (LINK_REG > 0) && (LINK_REG < 32);

    cu_state_e r_state;
    cu_state_e w_next;
    cu_dec_t   w_dec;
    logic      w_branch_taken;
    logic      w_unused_inst;

    cu_decode u_decode (
        .i_opcode (inst[INST_W-1 -: 6]),
        .i_funct  (inst[5:0]),
        .o_dec    (w_dec)
    );

    // Register-number and immediate fields belong to the datapath.
    assign w_unused_inst = ^inst[INST_W-7:6];

    assign w_branch_taken = w_dec.branch_ne ? ~alu_zero : alu_zero;
    assign cu_dbg_state   = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        cu_mem_re    = 1'b0;
        cu_mem_we    = 1'b0;
        cu_iord      = 1'b0;
        cu_ir_we     = 1'b0;
        cu_pc_we     = 1'b0;
        cu_pc_sel    = PC_SEL_PLUS4;
        cu_reg_we    = 1'b0;
        cu_write2rt  = 1'b0;
        cu_link      = 1'b0;
        cu_imm2alu   = 1'b0;
        cu_zero_ext  = 1'b0;
        cu_write_imm = 1'b0;
        cu_read_data = 1'b0;
        cu_alu_op    = '0;
        cu_illegal   = 1'b0;

        // ALU steering stays stable across EXEC, MEM and WB so the datapath
        // sees the same operation for the whole execute/writeback window.
        if (r_state == ST_EXEC || r_state == ST_MEM || r_state == ST_WB) begin
            cu_alu_op   = ALU_OP_W'(w_dec.alu_op);
            cu_imm2alu  = w_dec.itype & ~w_dec.branch;
            cu_zero_ext = w_dec.zero_ext;
        end

        case (r_state)
            ST_IDLE: begin
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                cu_mem_re = 1'b1;
                if (mem_ready) begin
                    cu_ir_we  = 1'b1;
                    cu_pc_we  = 1'b1;
                    cu_pc_sel = PC_SEL_PLUS4;
                    w_next    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_dec.illegal) begin
                    w_next = ST_TRAP;
                end else if (w_dec.jump) begin
                    cu_pc_we  = 1'b1;
                    cu_pc_sel = PC_SEL_JUMP;
                    cu_reg_we = w_dec.link & LINK_OK;
                    cu_link   = w_dec.link & LINK_OK;
                    w_next    = ST_FETCH;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_dec.branch) begin
                    if (w_branch_taken) begin
                        cu_pc_we  = 1'b1;
                        cu_pc_sel = PC_SEL_BRANCH;
                    end
                    w_next = ST_FETCH;
                end else if (w_dec.load || w_dec.store) begin
                    w_next = ST_MEM;
                end else begin
                    w_next = ST_WB;
                end
            end
            ST_MEM: begin
                cu_iord   = 1'b1;
                cu_alu_op = ALU_OP_W'(ALU_ADD);
                cu_mem_re = w_dec.load;
                cu_mem_we = w_dec.store;
                if (mem_ready) begin
                    w_next = w_dec.load ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                cu_reg_we    = 1'b1;
                cu_write2rt  = ~w_dec.rtype;
                cu_write_imm = w_dec.write_imm;
                cu_read_data = w_dec.load;
                w_next       = ST_FETCH;
            end
            ST_TRAP: begin
                cu_illegal = 1'b1;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

`ifdef CU_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_retire_cnt;
    logic        w_retire;

    // An instruction retires whenever control returns to FETCH from any
    // stage that follows the fetch itself.
    assign w_retire = (w_next == ST_FETCH) &&
                      (r_state == ST_DECODE || r_state == ST_EXEC ||
                       r_state == ST_MEM    || r_state == ST_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt  <= 32'd0;
            r_retire_cnt <= 32'd0;
        end else begin
            if (r_state != ST_IDLE && r_state != ST_TRAP) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    assign cu_cycle_cnt  = r_cycle_cnt;
    assign cu_retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_cu_multicycle.sv
// ----------------------------------------------------------------------------
// tb_cu_multicycle
// Instruction-level reference model for cu_multicycle. For every instruction
// the driver walks the phases the instruction must go through (fetch with
// memory wait, decode, execute, memory with wait, writeback, trap) and pushes
// the expected control word for each cycle; a monitor on the falling edge
// pops and compares against the DUT outputs.
// ----------------------------------------------------------------------------
module tb_cu_multicycle;

    typedef struct packed {
        logic       mem_re;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       reg_we;
        logic       write2rt;
        logic       link;
        logic       imm2alu;
        logic       zero_ext;
        logic       write_imm;
        logic       read_data;
        logic [2:0] alu_op;
        logic       illegal;
    } ctl_t;

    localparam int CW = $bits(ctl_t);

    typedef enum int {K_R, K_ALUI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_e;

    localparam logic [2:0] A_ADD = 3'd0;
    localparam logic [2:0] A_SUB = 3'd1;
    localparam logic [2:0] A_AND = 3'd2;
    localparam logic [2:0] A_OR  = 3'd3;
    localparam logic [2:0] A_SLT = 3'd4;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = 32'd0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        cu_mem_re, cu_mem_we, cu_iord, cu_ir_we, cu_pc_we;
    logic [1:0]  cu_pc_sel;
    logic        cu_reg_we, cu_write2rt, cu_link, cu_imm2alu, cu_zero_ext;
    logic        cu_write_imm, cu_read_data, cu_illegal;
    logic [2:0]  cu_alu_op;
    logic [2:0]  dbg_state;
`ifdef CU_PERF_CNT_EN
    logic [31:0] cycle_cnt, retire_cnt;
`endif

    always #5 clk = ~clk;

    cu_multicycle dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst         (inst),
        .alu_zero     (alu_zero),
        .mem_ready    (mem_ready),
        .cu_mem_re    (cu_mem_re),
        .cu_mem_we    (cu_mem_we),
        .cu_iord      (cu_iord),
        .cu_ir_we     (cu_ir_we),
        .cu_pc_we     (cu_pc_we),
        .cu_pc_sel    (cu_pc_sel),
        .cu_reg_we    (cu_reg_we),
        .cu_write2rt  (cu_write2rt),
        .cu_link      (cu_link),
        .cu_imm2alu   (cu_imm2alu),
        .cu_zero_ext  (cu_zero_ext),
        .cu_write_imm (cu_write_imm),
        .cu_read_data (cu_read_data),
        .cu_alu_op    (cu_alu_op),
        .cu_illegal   (cu_illegal),
`ifdef CU_PERF_CNT_EN
        .cu_cycle_cnt (cycle_cnt),
        .cu_retire_cnt(retire_cnt),
`endif
        .cu_dbg_state (dbg_state)
    );

    ctl_t act;
    always_comb begin
        act           = '0;
        act.mem_re    = cu_mem_re;
        act.mem_we    = cu_mem_we;
        act.iord      = cu_iord;
        act.ir_we     = cu_ir_we;
        act.pc_we     = cu_pc_we;
        act.pc_sel    = cu_pc_sel;
        act.reg_we    = cu_reg_we;
        act.write2rt  = cu_write2rt;
        act.link      = cu_link;
        act.imm2alu   = cu_imm2alu;
        act.zero_ext  = cu_zero_ext;
        act.write_imm = cu_write_imm;
        act.read_data = cu_read_data;
        act.alu_op    = cu_alu_op;
        act.illegal   = cu_illegal;
    end

    // ---------------- scoreboard ----------------
    logic [CW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            logic [CW-1:0] e;
            e = exp_q.pop_front();
            total++;
            if (act !== ctl_t'(e)) begin
                bad++;
                $display("FAIL ctl_word cyc=%0d inst=%h act=%h exp=%h", cyc, inst, act, e);
            end
        end
    end

    task automatic check_bit(input string name, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%b exp=%b", name, a, e);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic classify(input logic [31:0] ins, output kind_e k,
                            output logic [2:0] alu, output logic imm, output logic zx);
        k = K_ILL; alu = A_ADD; imm = 1'b0; zx = 1'b0;
        case (ins[31:26])
            6'h00: begin
                k = K_R;
                case (ins[5:0])
                    6'h21: alu = A_ADD;
                    6'h23: alu = A_SUB;
                    6'h24: alu = A_AND;
                    6'h25: alu = A_OR;
                    6'h2A: alu = A_SLT;
                    default: k = K_ILL;
                endcase
            end
            6'h09: begin k = K_ALUI; imm = 1'b1; end
            6'h0C: begin k = K_ALUI; imm = 1'b1; zx = 1'b1; alu = A_AND; end
            6'h0D: begin k = K_ALUI; imm = 1'b1; zx = 1'b1; alu = A_OR;  end
            6'h0F: begin k = K_LUI;  imm = 1'b1; end
            6'h23: begin k = K_LW;   imm = 1'b1; end
            6'h2B: begin k = K_SW;   imm = 1'b1; end
            6'h04: begin k = K_BEQ;  alu = A_SUB; end
            6'h05: begin k = K_BNE;  alu = A_SUB; end
            6'h02: k = K_J;
            6'h03: k = K_JAL;
            default: k = K_ILL;
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic step(input ctl_t e, input logic rdy, input logic z);
        mem_ready = rdy;
        alu_zero  = z;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step('0, rnd(), rnd());
        rst_n = 1'b1;
        step('0, rnd(), rnd());   // IDLE cycle after release
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic z, input int fw, input int mw);
        ctl_t e, st;
        kind_e k;
        logic [2:0] alu;
        logic imm, zx, taken;
        inst = ins;
        classify(ins, k, alu, imm, zx);
        // fetch
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mem_re = 1'b1;
            step(e, 1'b0, rnd());
        end
        e = '0; e.mem_re = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
        step(e, 1'b1, rnd());
        // decode
        e = '0;
        if (k == K_J || k == K_JAL) begin
            e.pc_we = 1'b1; e.pc_sel = 2'd2;
            if (k == K_JAL) begin e.reg_we = 1'b1; e.link = 1'b1; end
            step(e, rnd(), rnd());
            return;
        end
        step(e, rnd(), rnd());
        if (k == K_ILL) begin
            for (int i = 0; i < 12; i++) begin
                e = '0; e.illegal = 1'b1;
                step(e, rnd(), rnd());
            end
            do_reset();
            return;
        end
        // execute
        st = '0; st.alu_op = alu; st.imm2alu = imm; st.zero_ext = zx;
        e = st;
        if (k == K_BEQ || k == K_BNE) begin
            taken = (k == K_BEQ) ? z : ~z;
            if (taken) begin e.pc_we = 1'b1; e.pc_sel = 2'd1; end
            step(e, rnd(), z);
            return;
        end
        step(e, rnd(), rnd());
        // memory
        if (k == K_LW || k == K_SW) begin
            e = st; e.iord = 1'b1; e.alu_op = A_ADD;
            e.mem_re = (k == K_LW); e.mem_we = (k == K_SW);
            for (int i = 0; i < mw; i++) step(e, 1'b0, rnd());
            step(e, 1'b1, rnd());
            if (k == K_SW) return;
        end
        // writeback
        e = st; e.reg_we = 1'b1; e.write2rt = (k != K_R);
        e.write_imm = (k == K_LUI); e.read_data = (k == K_LW);
        step(e, rnd(), rnd());
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0]  ops [0:10];
        logic [5:0]  fns [0:4];
        logic [31:0] r;
        int idx;
        ops = '{6'h00, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
        fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};
        r = $urandom;
        idx = $urandom_range(0, 12);
        r[31:26] = (idx <= 10) ? ops[idx] : 6'($urandom);
        if (r[31:26] == 6'h00 && $urandom_range(0, 7) != 0)
            r[5:0] = fns[$urandom_range(0, 4)];
        return r;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        ctl_t e;
        @(posedge clk);
        #1;
        do_reset();

        // directed cases
        run_instr(32'h00221821, 1'b0, 0, 0);   // addu
        run_instr(32'h8C220004, 1'b0, 0, 3);   // lw, memory stalls 3 cycles
        run_instr(32'h10220003, 1'b1, 0, 0);   // beq taken
        run_instr(32'h10220003, 1'b0, 0, 0);   // beq not taken
        run_instr(32'h14220003, 1'b1, 0, 0);   // bne not taken
        run_instr(32'h14220003, 1'b0, 0, 0);   // bne taken
        run_instr(32'h0C000010, 1'b0, 0, 0);   // jal
        run_instr(32'h08000020, 1'b0, 2, 0);   // j with fetch stall
        run_instr(32'h3C011234, 1'b0, 0, 0);   // lui
        run_instr(32'h3022FFFF, 1'b0, 1, 0);   // andi
        run_instr(32'hAC220004, 1'b0, 0, 2);   // sw
        run_instr(32'h00221827, 1'b0, 0, 0);   // R-type with bad funct -> trap
        run_instr(32'hFC000000, 1'b0, 0, 0);   // opcode 0x3F -> trap

        // reset while sw waits in MEM
        inst = 32'hAC220004;
        e = '0; e.mem_re = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
        step(e, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0);
        e = '0; e.imm2alu = 1'b1;
        step(e, 1'b0, 1'b0);
        e = '0; e.imm2alu = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1;
        step(e, 1'b0, 1'b0);
        check_bit("mem_we_before_reset", cu_mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("mem_we_in_reset", cu_mem_we, 1'b0);
        check_bit("iord_in_reset", cu_iord, 1'b0);
        step('0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step('0, 1'b0, 1'b0);
        run_instr(32'h00221821, 1'b0, 1, 0);   // first request is a fetch read

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            run_instr(rand_inst(), rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cu_multicycle.md
Name: cu_multicycle

Overview:
Multi-cycle control unit for the MIPS-subset core. It is the sequential successor of the single-cycle decoder. The FSM drives a shared-memory, variable-latency datapath (FETCH/DECODE/EXEC/MEM/WB) and handshakes with memory through a ready signal. Compared with the single-cycle unit it adds R-type funct decoding, bne, jal, a multi-bit ALU op and illegal-instruction detection.

Parameters:
INST_W, 32, instruction width; opcode at [INST_W-1 -: 6], funct at [5:0]
ALU_OP_W, 3, width of cu_alu_op
LINK_REG, 31, register index written by jal

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
inst  in  INST_W  IR contents; valid from DECODE onward
alu_zero  in  1  ALU result == 0, sampled in EXEC
mem_ready  in  1  memory completes the current access this cycle
cu_mem_re  out  1  memory read request (instruction or lw)
cu_mem_we  out  1  memory write request (sw)
cu_iord  out  1  0 = address from PC, 1 = address from ALU result
cu_ir_we  out  1  load IR from memory read data
cu_pc_we  out  1  update PC
cu_pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target
cu_reg_we  out  1  register file write
cu_write2rt  out  1  destination is rt (else rd)
cu_link  out  1  destination is LINK_REG, data is PC (jal)
cu_imm2alu  out  1  ALU B operand is imm (else rt)
cu_zero_ext  out  1  zero-extend imm (andi/ori), else sign-extend
cu_write_imm  out  1  write imm<<16 (lui)
cu_read_data  out  1  writeback data from memory (lw)
cu_alu_op  out  ALU_OP_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
cu_illegal  out  1  sticky illegal-opcode/funct flag

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. State register is async-reset to IDLE.
- Outputs are combinational from the state register plus `inst`. In IDLE every output is 0. During reset all outputs are 0.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH:
  - cu_mem_re=1, cu_iord=0.
  - Held while mem_ready=0.
  - In the cycle mem_ready=1: cu_ir_we=1, cu_pc_we=1, pc_sel=0, then -> DECODE.
- DECODE (1 cycle):
  - Decodes opcode/funct.
  - j: pc_we, pc_sel=2, -> FETCH.
  - jal: pc_we, pc_sel=2, reg_we, link=1, -> FETCH.
  - Unsupported encoding: -> TRAP.
  - All other valid encodings: -> EXEC.
- Legal set:
  - R-type funct addu 0x21, subu 0x23, and 0x24, or 0x25, slt 0x2A.
  - addiu 0x09, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03.
- EXEC (1 cycle), alu_op per instruction:
  - addiu/lw/sw: ADD.
  - beq/bne: SUB; pc_we=1, pc_sel=1 iff (beq & alu_zero) | (bne & ~alu_zero); then -> FETCH.
  - lw/sw -> MEM.
  - All others -> WB.
- MEM:
  - iord=1, alu_op held ADD.
  - lw: mem_re=1; sw: mem_we=1.
  - Request held until mem_ready=1; then lw -> WB, sw -> FETCH.
  - mem_we is never asserted outside MEM.
- WB (1 cycle):
  - reg_we=1.
  - write2rt=1 for I-type; zero_ext for andi/ori; write_imm for lui; read_data for lw.
  - alu_op is held as in EXEC.
  - Then -> FETCH.
- TRAP: cu_illegal=1, all strobes 0, stays until rst_n.
- Reset mid-operation: immediate return to IDLE. An in-flight memory request is dropped combinationally; no write strobe survives reset.
- Instruction latency with mem_ready tied high:
  - j/jal: 2 cycles.
  - beq/bne: 3 cycles.
  - R/I ALU ops and sw: 4 cycles.
  - lw: 5 cycles.

Optional Feature:
CU_PERF_CNT_EN.
- Defined:
  - Adds outputs cu_cycle_cnt [31:0] and cu_retire_cnt [31:0], both async-reset to 0.
  - cycle_cnt increments every cycle outside IDLE/TRAP.
  - retire_cnt increments on each transition into FETCH from DECODE, EXEC, MEM or WB.
  - Both wrap modulo 2^32.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package cu_pkg holds:
  - state enum;
  - opcode/funct localparams;
  - ALU op encodings;
  - pc_sel encodings.
- One sub-module, cu_decode: purely combinational inst -> instruction class (rtype, itype, load, store, branch, jump, link, illegal) plus alu_op. It is instantiated once; the FSM consumes its outputs.

Test Plan:
- addu (0x00221821), mem_ready=1 -> IDLE, FETCH, DECODE, EXEC, WB. reg_we=1 only in WB, write2rt=0, alu_op=0. 5 cycles from reset release.
- lw 0x8C220004 with mem_ready low 3 cycles in MEM -> mem_re and iord held 4 cycles. Then WB with read_data=1, write2rt=1. mem_we never 1.
- beq 0x10220003 with alu_zero=1 -> in EXEC pc_we=1, pc_sel=1. With alu_zero=0 -> pc_we=0. bne is the inverse.
- jal 0x0C000010 -> in DECODE pc_we=1, pc_sel=2, reg_we=1, link=1. Next state FETCH.
- Opcode 0x3F -> TRAP after DECODE, cu_illegal=1 persists 10+ cycles, all strobes 0. rst_n low then high -> IDLE and illegal=0.
- Assert rst_n=0 during sw in MEM with mem_ready=0 -> mem_we drops to 0 the same cycle. After release, the first request is a FETCH read.
